board_pixel_source: RTL and testbench
=====================================

# board_pixel_source

Pixel producer for the VGA renderer. It consumes the renderer's per-clock pixel coordinates and viewable-area flag, and returns an 8-bit RGB332 pixel with an enable at a fixed 2-cycle latency. Colours come from a 10×20 Tetrix playfield cell store, a fixed palette and a board border. Game logic updates cells through a valid/ready write port, and a sweep FSM clears the board on request and after reset.

## Interface
- `BOARD_X0`, default 320: x of the board's first cell pixel.
- `BOARD_Y0`, default 140: y of the board's first cell pixel.
- `CELL_LOG2`, default 4: cell edge is 2^CELL_LOG2 pixels; the board is 160×320 px at the default.
- `BORDER_W`, default 2: border thickness in pixels, drawn outside the board.
- `clk`, in, 1: pixel clock, 50 MHz.
- `rst`, in, 1: reset, synchronous, active-high.
- `pixel_x`, in, 10: current pixel column from the renderer.
- `pixel_y`, in, 10: current pixel row from the renderer.
- `in_view`, in, 1: renderer viewable-area flag.
- `pixel_bus`, out, 8: RGB332 pixel, bits [7:5]=R, [4:2]=G, [1:0]=B.
- `pixel_bus_enable`, out, 1: `pixel_bus` is valid and the renderer must use it.
- `wr_valid`, in, 1: cell write request.
- `wr_ready`, out, 1: write accepted when `wr_valid` and `wr_ready` are both high.
- `wr_row`, in, 5: cell row, 0..19; 0 is the top row.
- `wr_col`, in, 4: cell column, 0..9; 0 is the left column.
- `wr_color`, in, 3: palette index; 0 means empty.
- `clr_req`, in, 1: one-cycle pulse that starts a board clear.
- `busy`, out, 1: clear sweep is in progress.

## Operation
- Cell store: 200 entries × 3 bits, indexed row*10+col. One synchronous read port serves the pixel path; one write port is shared by the write handshake and the clear sweep.
- Pixel classification, from registered coordinates:
  - board: BOARD_X0 ≤ x < BOARD_X0+160 and BOARD_Y0 ≤ y < BOARD_Y0+320.
  - border: inside the board expanded by BORDER_W on every side, and not board.
  - other: everything else.
- Cell address: col = (x−BOARD_X0)>>CELL_LOG2, row = (y−BOARD_Y0)>>CELL_LOG2. Subtraction is 10-bit and is only used when the pixel is classified board.
- Pixel colour:
  - board, index 0: BG_COLOR.
  - board, index nonzero: PALETTE[index].
  - board, cell-local x or y == 0: GRID_COLOR overrides the two cases above.
  - border: BORDER_COLOR.
  - other: `pixel_bus` = 0 and `pixel_bus_enable` = 0.
- `pixel_bus_enable` = delayed `in_view` AND (board OR border). When `in_view` is low, `pixel_bus` = 0.
- FSM states:
  - IDLE: `wr_ready`=1, `busy`=0.
  - CLEAR: `wr_ready`=0, `busy`=1. An internal 8-bit pointer writes 0 to cell ptr each cycle, running 0..199. After writing cell 199 the FSM returns to IDLE on the next edge.
- IDLE→CLEAR on `clr_req`. In CLEAR, `clr_req` is ignored; the sweep is not restarted.
- Reset enters CLEAR with ptr=0. Reset during a sweep restarts it at 0.
- A write is accepted in IDLE when `wr_valid` is high. The cell is updated on that edge. If `wr_row` > 19 or `wr_col` > 9, the write is accepted (handshake completes) and dropped.
- Simultaneous `wr_valid` and `clr_req` in IDLE: the write is accepted and performed, then the sweep starts on the next cycle, so the cell ends at 0.
- Read and write of the same cell in the same cycle: the pixel path sees the old value.

## Timing
- Latency: coordinates and `in_view` sampled at edge N produce `pixel_bus` and `pixel_bus_enable` registered at edge N+2. The latency is constant for every pixel class.
  - Stage 1: register coordinates, classification and cell-local flags; present the read address.
  - Stage 2: palette/override mux into the output registers.
- Reset values: `pixel_bus`=0, `pixel_bus_enable`=0, `wr_ready`=0, `busy`=1. Both pipeline stages are flushed to class "other".
- `busy` stays high for exactly 200 cycles after the reset-release edge, or after the `clr_req` edge.
- `wr_ready` is a registered state decode. It never changes combinationally with `wr_valid`.

## Structure
- Package `tetrix_pkg` holds:
  - BOARD_COLS=10 and BOARD_ROWS=20.
  - The RGB332 constants BG_COLOR=8'h00, GRID_COLOR=8'h25, BORDER_COLOR=8'hFF.
  - PALETTE[1..7]: 8'hE0, 8'h1C, 8'h03, 8'hFC, 8'hE3, 8'h1F, 8'hF0.
  - The FSM state enum.
- One sub-module, `cell_store`: 200×3 RAM with a synchronous read port and a write port. The FSM and pixel pipeline live in `board_pixel_source`.

## Test plan
- Reset, then idle 205 cycles → `busy`=1 for cycles 0..199 and 0 from cycle 200; `wr_ready` rises with `busy` falling. Sweep every pixel → only BG_COLOR, GRID_COLOR and BORDER_COLOR appear.
- Write row 0, col 0, colour 1; drive (x,y)=(321,141) with `in_view`=1 → two cycles later `pixel_bus`=8'hE0, `pixel_bus_enable`=1. At (320,141) → 8'h25.
- Drive (319,200) → BORDER_COLOR with enable. Drive (317,200) → enable 0, bus 0. Drive (321,141) with `in_view`=0 → enable 0.
- Write row 25, col 3 → handshake completes and no cell changes. Write row 19, col 9, colour 7, then drive (475,455) → 8'hF0.
- Fill cells, then pulse `clr_req` together with `wr_valid` (row 5, col 5, colour 2) → write accepted; `wr_ready`=0 for 200 cycles; a second `clr_req` mid-sweep does not extend `busy`; all cells read empty afterwards.
- Assert `rst` at sweep cycle 100 → `busy` stays high for a further 200 cycles after release.

Source files
------------

// File: rtl/tetrix_pkg.sv
// Shared constants for the Tetrix board renderer.
//
// Holds the playfield dimensions, the RGB332 colour constants, the cell
// palette and the clear-sweep FSM state type. RGB332 packs R in [7:5],
// G in [4:2] and B in [1:0].
package tetrix_pkg;

    localparam int BOARD_COLS = 10;
    localparam int BOARD_ROWS = 20;
    localparam int CELL_COUNT = BOARD_COLS * BOARD_ROWS;

    localparam logic [7:0] BG_COLOR     = 8'h00;
    localparam logic [7:0] GRID_COLOR   = 8'h25;
    localparam logic [7:0] BORDER_COLOR = 8'hFF;

    // Entry 0 is the empty cell, so indexing with a raw cell value gives
    // the background colour without a separate compare.
    localparam logic [7:0] PALETTE [0:7] = '{
        BG_COLOR, 8'hE0, 8'h1C, 8'h03, 8'hFC, 8'hE3, 8'h1F, 8'hF0
    };

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clear_state_e;

endpackage

// File: rtl/board_pixel_source_cell_store.sv
// cell_store: playfield cell memory, one 3-bit palette index per cell.
//
// Ports:
//   clk      - clock
//   rd_addr  - read address (row*10+col)
//   rd_data  - registered read data, valid the cycle after rd_addr
//   wr_en    - write enable
//   wr_addr  - write address
//   wr_data  - write data
//
// The read is registered from the array contents before the edge's write,
// so a same-cycle read and write of one cell returns the old value.
module cell_store
    import tetrix_pkg::*;
#(
    parameter int DEPTH = CELL_COUNT,
    parameter int AW    = 8,
    parameter int DW    = 3
) (
    input  logic          clk,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/board_pixel_source.sv
// board_pixel_source: pixel producer for the VGA renderer.
//
// Turns renderer coordinates into an RGB332 pixel with a fixed two-cycle
// latency. Board pixels show the cell palette with a one-pixel grid on each
// cell's top and left edge, a border of BORDER_W pixels surrounds the board,
// and everything else is not driven (enable low, bus zero).
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   pixel_x, pixel_y  - renderer coordinates (10 bit)
//   in_view           - renderer viewable-area flag
//   pixel_bus         - RGB332 pixel out
//   pixel_bus_enable  - pixel_bus is valid
//   wr_valid/wr_ready - cell write handshake
//   wr_row, wr_col    - target cell (out-of-range writes are accepted, dropped)
//   wr_color          - palette index, 0 = empty
//   clr_req           - pulse that starts a full-board clear
//   busy              - clear sweep in progress
module board_pixel_source
    import tetrix_pkg::*;
#(
    parameter int BOARD_X0  = 320,
    parameter int BOARD_Y0  = 140,
    parameter int CELL_LOG2 = 4,
    parameter int BORDER_W  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       in_view,
    output logic [7:0] pixel_bus,
    output logic       pixel_bus_enable,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [4:0] wr_row,
    input  logic [3:0] wr_col,
    input  logic [2:0] wr_color,
    input  logic       clr_req,
    output logic       busy
);

    localparam int BOARD_W_PX = BOARD_COLS << CELL_LOG2;
    localparam int BOARD_H_PX = BOARD_ROWS << CELL_LOG2;

    // Bounds are compared in 12 bits so the border's lower edge never wraps.
    localparam logic [11:0] X0_EXT     = 12'(BOARD_X0);
    localparam logic [11:0] Y0_EXT     = 12'(BOARD_Y0);
    localparam logic [11:0] X_END      = 12'(BOARD_X0 + BOARD_W_PX);
    localparam logic [11:0] Y_END      = 12'(BOARD_Y0 + BOARD_H_PX);
    localparam logic [11:0] XB_END     = 12'(BOARD_X0 + BOARD_W_PX + BORDER_W);
    localparam logic [11:0] YB_END     = 12'(BOARD_Y0 + BOARD_H_PX + BORDER_W);
    localparam logic [11:0] BW_EXT     = 12'(BORDER_W);
    localparam logic [9:0]  CELL_MASK  = 10'((1 << CELL_LOG2) - 1);
    localparam logic [7:0]  LAST_CELL  = 8'(CELL_COUNT - 1);

    // ------------------------------------------------------------------
    // Stage 1: registered coordinates
    // ------------------------------------------------------------------
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       view1_q, view1_d;

    always_comb begin
        x_d     = pixel_x;
        y_d     = pixel_y;
        view1_d = in_view;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            view1_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            view1_q <= view1_d;
        end
    end

    // Classification and cell address from the registered coordinates.
    logic [11:0] x_ext, y_ext;
    logic [9:0]  dx, dy;
    logic        is_board, is_border, is_grid;
    logic [7:0]  rd_addr;

    always_comb begin
        x_ext     = {2'b00, x_q};
        y_ext     = {2'b00, y_q};
        dx        = x_q - 10'(BOARD_X0);
        dy        = y_q - 10'(BOARD_Y0);
        is_board  = (x_ext >= X0_EXT) && (x_ext < X_END) &&
                    (y_ext >= Y0_EXT) && (y_ext < Y_END);
        is_border = !is_board &&
                    (x_ext + BW_EXT >= X0_EXT) && (x_ext < XB_END) &&
                    (y_ext + BW_EXT >= Y0_EXT) && (y_ext < YB_END);
        // Top or left pixel of a cell draws the grid line.
        is_grid   = ((dx & CELL_MASK) == 10'd0) || ((dy & CELL_MASK) == 10'd0);
        // Off-board pixels read cell 0 so the address always stays in range.
        rd_addr   = is_board
                  ? 8'(((dy >> CELL_LOG2) * BOARD_COLS) + (dx >> CELL_LOG2))
                  : 8'd0;
    end

    // ------------------------------------------------------------------
    // Stage 2: class flags travel alongside the RAM read
    // ------------------------------------------------------------------
    logic board2_q, board2_d;
    logic border2_q, border2_d;
    logic grid2_q, grid2_d;
    logic view2_q, view2_d;

    always_comb begin
        board2_d  = is_board;
        border2_d = is_border;
        grid2_d   = is_grid;
        view2_d   = view1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            board2_q  <= 1'b0;
            border2_q <= 1'b0;
            grid2_q   <= 1'b0;
            view2_q   <= 1'b0;
        end else begin
            board2_q  <= board2_d;
            border2_q <= border2_d;
            grid2_q   <= grid2_d;
            view2_q   <= view2_d;
        end
    end

    // ------------------------------------------------------------------
    // Output mux
    // ------------------------------------------------------------------
    logic [2:0] rd_data;
    logic [7:0] pixel_bus_q, pixel_bus_d;
    logic       pixel_bus_enable_q, pixel_bus_enable_d;

    always_comb begin
        pixel_bus_d        = 8'h00;
        pixel_bus_enable_d = 1'b0;
        if (view2_q) begin
            if (board2_q) begin
                pixel_bus_enable_d = 1'b1;
                pixel_bus_d        = grid2_q ? GRID_COLOR : PALETTE[rd_data];
            end else if (border2_q) begin
                pixel_bus_enable_d = 1'b1;
                pixel_bus_d        = BORDER_COLOR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_bus_q        <= 8'h00;
            pixel_bus_enable_q <= 1'b0;
        end else begin
            pixel_bus_q        <= pixel_bus_d;
            pixel_bus_enable_q <= pixel_bus_enable_d;
        end
    end

    assign pixel_bus        = pixel_bus_q;
    assign pixel_bus_enable = pixel_bus_enable_q;

    // ------------------------------------------------------------------
    // Clear sweep FSM; busy and wr_ready are registered state decodes
    // ------------------------------------------------------------------
    clear_state_e state_q;
    logic [7:0]   ptr_q;
    logic         busy_q;
    logic         wr_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            ptr_q      <= 8'd0;
            busy_q     <= 1'b1;
            wr_ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A write presented alongside clr_req is still performed
                    // on this edge; the sweep then overwrites it.
                    if (clr_req) begin
                        state_q    <= ST_CLEAR;
                        ptr_q      <= 8'd0;
                        busy_q     <= 1'b1;
                        wr_ready_q <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (ptr_q == LAST_CELL) begin
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        wr_ready_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + 8'd1;
                    end
                end
                default: begin
                    state_q    <= ST_CLEAR;
                    ptr_q      <= 8'd0;
                    busy_q     <= 1'b1;
                    wr_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign wr_ready = wr_ready_q;

    // Shared write port: the sweep owns it while clearing.
    logic       wr_in_range;
    logic       ram_we;
    logic [7:0] ram_waddr;
    logic [2:0] ram_wdata;

    always_comb begin
        wr_in_range = (wr_row < 5'(BOARD_ROWS)) && (wr_col < 4'(BOARD_COLS));
        ram_we      = 1'b0;
        ram_waddr   = 8'd0;
        ram_wdata   = 3'd0;
        if (state_q == ST_CLEAR) begin
            ram_we    = !rst;
            ram_waddr = ptr_q;
        end else begin
            ram_we    = !rst && wr_valid && wr_in_range;
            ram_waddr = 8'((wr_row * BOARD_COLS) + wr_col);
            ram_wdata = wr_color;
        end
    end

    cell_store #(
        .DEPTH (CELL_COUNT),
        .AW    (8),
        .DW    (3)
    ) u_cell_store (
        .clk     (clk),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata)
    );

endmodule

// File: tb/tb_board_pixel_source.sv
// Testbench for board_pixel_source: a behavioural board model (cell array,
// clear countdown, pixel geometry by integer division) checked against the
// DUT every cycle, plus literal expectations for a few fixed pixels and
// the busy-window lengths.
module tb_board_pixel_source;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] pixel_x = '0;
    logic [9:0] pixel_y = '0;
    logic       in_view = 1'b0;
    logic [7:0] pixel_bus;
    logic       pixel_bus_enable;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [4:0] wr_row = '0;
    logic [3:0] wr_col = '0;
    logic [2:0] wr_color = '0;
    logic       clr_req = 1'b0;
    logic       busy;

    board_pixel_source dut (
        .clk              (clk),
        .rst              (rst),
        .pixel_x          (pixel_x),
        .pixel_y          (pixel_y),
        .in_view          (in_view),
        .pixel_bus        (pixel_bus),
        .pixel_bus_enable (pixel_bus_enable),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .wr_row           (wr_row),
        .wr_col           (wr_col),
        .wr_color         (wr_color),
        .clr_req          (clr_req),
        .busy             (busy)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int pal [8] = '{0, 'hE0, 'h1C, 'h03, 'hFC, 'hE3, 'h1F, 'hF0};
    int mem_m [200];          // -1 = contents not yet known
    int remaining = 0;        // clear cycles still to run
    bit model_on  = 0;

    typedef struct {
        bit known;
        int bus;
        int en;
    } exp_t;

    exp_t q[$];
    exp_t exp_now;
    exp_t zero_e = '{1'b1, 0, 0};

    function automatic exp_t pix_model(int x, int y, int iv);
        exp_t e;
        int bx, by, v;
        e = '{1'b1, 0, 0};
        if (iv == 0) return e;
        bx = x - 320;
        by = y - 140;
        if (bx >= 0 && bx < 160 && by >= 0 && by < 320) begin
            e.en = 1;
            if (bx % 16 == 0 || by % 16 == 0) begin
                e.bus = 'h25;
            end else begin
                v = mem_m[(by / 16) * 10 + bx / 16];
                if (v < 0) e.known = 1'b0;
                else       e.bus   = pal[v];
            end
        end else if (bx >= -2 && bx < 162 && by >= -2 && by < 322) begin
            e.en  = 1;
            e.bus = 'hFF;
        end
        return e;
    endfunction

    initial begin
        for (int i = 0; i < 200; i++) mem_m[i] = -1;
        forever begin
            @(posedge clk);
            if (rst) begin
                model_on  = 1;
                remaining = 200;
                q.delete();
                q.push_back(zero_e);
                q.push_back(zero_e);
                exp_now = zero_e;
            end else if (model_on) begin
                if (remaining > 0) begin
                    mem_m[200 - remaining] = 0;
                    remaining--;
                end else begin
                    if (wr_valid && wr_row < 20 && wr_col < 10)
                        mem_m[int'(wr_row) * 10 + int'(wr_col)] = int'(wr_color);
                    if (clr_req) remaining = 200;
                end
                q.push_back(pix_model(int'(pixel_x), int'(pixel_y), int'(in_view)));
                exp_now = q.pop_front();
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                check("busy", int'(busy), int'(remaining > 0));
                check("wr_ready", int'(wr_ready), int'(remaining == 0));
                if (exp_now.known) begin
                    check("pixel_bus", int'(pixel_bus), exp_now.bus);
                    check("pixel_en", int'(pixel_bus_enable), exp_now.en);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int x, input int y, input bit iv);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        in_view = iv;
    endtask

    task automatic lit_pix(input string name, input int x, input int y, input bit iv,
                           input int eb, input int ee);
        set_pix(x, y, iv);
        repeat (3) tick();
        check({name, "_bus"}, int'(pixel_bus), eb);
        check({name, "_en"}, int'(pixel_bus_enable), ee);
    endtask

    task automatic do_write(input int r, input int c, input int col, output bit ok);
        wr_row   = 5'(r);
        wr_col   = 4'(c);
        wr_color = 3'(col);
        wr_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            if (wr_ready) ok = 1'b1;
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 1000) begin
            n++;
            tick();
        end
        check("wait_idle_timeout", int'(busy), 0);
    endtask

    task automatic busy_len(input string name, input int pulse_at);
        int cnt;
        cnt = 0;
        while (busy && cnt < 1000) begin
            cnt++;
            if (cnt == pulse_at) clr_req = 1'b1;
            tick();
            clr_req = 1'b0;
        end
        check(name, cnt, 200);
    endtask

    initial begin
        #1500us;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Busy window after reset release.
        for (int k = 0; k < 205; k++) begin
            if (k == 0 || k == 199 || k == 200 || k == 204) begin
                check("rst_busy", int'(busy), int'(k < 200));
                check("rst_ready", int'(wr_ready), int'(k >= 200));
            end
            tick();
        end

        // Coarse scan of an empty board: only BG, grid and border colours.
        for (int y = 130; y < 470; y += 6)
            for (int x = 312; x < 490; x += 5) begin
                set_pix(x, y, 1'b1);
                tick();
            end

        do_write(0, 0, 1, ok);
        check("wr_accept", int'(ok), 1);
        lit_pix("cell00", 321, 141, 1'b1, 'hE0, 1);
        lit_pix("grid", 320, 141, 1'b1, 'h25, 1);
        lit_pix("border", 319, 200, 1'b1, 'hFF, 1);
        lit_pix("outside", 317, 200, 1'b1, 'h00, 0);
        lit_pix("noview", 321, 141, 1'b0, 'h00, 0);
        do_write(25, 3, 5, ok);
        check("wr_oob_accept", int'(ok), 1);
        do_write(19, 9, 7, ok);
        check("wr_last_accept", int'(ok), 1);
        lit_pix("cell199", 475, 455, 1'b1, 'hF0, 1);

        // Randomised pixels and writes, with rare clear requests.
        for (int i = 0; i < 2000; i++) begin
            set_pix(300 + $urandom_range(0, 200), 130 + $urandom_range(0, 350),
                    $urandom_range(0, 9) != 0);
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_row   = 5'($urandom_range(0, 21));
            wr_col   = 4'($urandom_range(0, 11));
            wr_color = 3'($urandom);
            clr_req  = ($urandom_range(0, 699) == 0);
            tick();
        end
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        wait_idle();

        // Fill a few cells, then clear together with a write.
        do_write(5, 5, 3, ok);
        do_write(0, 0, 4, ok);
        do_write(10, 2, 6, ok);
        check("ready_before_clr", int'(wr_ready), 1);
        wr_row = 5'd5; wr_col = 4'd5; wr_color = 3'd2;
        wr_valid = 1'b1;
        clr_req  = 1'b1;
        tick();
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        check("clr_busy", int'(busy), 1);
        check("clr_ready", int'(wr_ready), 0);
        busy_len("clr_len", 100);
        lit_pix("cleared55", 408, 228, 1'b1, 'h00, 1);
        lit_pix("cleared00", 328, 148, 1'b1, 'h00, 1);
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++) begin
                set_pix(328 + 16 * c, 148 + 16 * r, 1'b1);
                tick();
            end

        // Reset in the middle of a sweep restarts it.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (99) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        busy_len("rst_mid_len", 0);
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
